// File: rtl/mips_multiciclo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_multiciclo : multi-cycle MIPS-subset core, one ALU, one req/ready    |
// |                   unified memory port with wait-state support             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mips_multiciclo #(
  parameter int unsigned RESET_PC        = 0,
  parameter int unsigned ADDR_W          = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW  = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]       alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic [31:0]       rf_q [32];

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, pc_ext, jump_tgt, alu_res;
  logic        legal;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_ext   = 32'(pc_q);
  assign jump_tgt = {pc_ext[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                        (funct == F_OR)  || (funct == F_SLT);
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    case (funct)
      F_SUB:   alu_res = a_q - b_q;
      F_AND:   alu_res = a_q & b_q;
      F_OR:    alu_res = a_q | b_q;
      F_SLT:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      default: alu_res = a_q + b_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_out_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = b_q;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d       = rf_q[rs];
        b_d       = rf_q[rt];
        alu_out_d = pc_ext + (imm_sext << 2);
        if (!legal) state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        else        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_RTYPE: begin alu_out_d = alu_res;        state_d = S_WB;  end
          OP_ADDI:  begin alu_out_d = a_q + imm_sext; state_d = S_WB;  end
          OP_LW, OP_SW: begin alu_out_d = a_q + imm_sext; state_d = S_MEM; end
          OP_BEQ:   if (a_q == b_q) pc_d = alu_out_q[ADDR_W-1:0];
          OP_BNE:   if (a_q != b_q) pc_d = alu_out_q[ADDR_W-1:0];
          OP_J:     pc_d = jump_tgt[ADDR_W-1:0];
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_SW);
        mem_addr = alu_out_q[ADDR_W-1:0];
        if (mem_ready) begin
          if (op == OP_SW) state_d = S_FETCH;
          else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
        if (op == OP_RTYPE)  rf_waddr = rd;
        else if (op == OP_LW) rf_wdata = mdr_q;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // A request in flight when reset hits is abandoned without side effects.
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= ADDR_W'(RESET_PC);
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign halted = (state_q == S_HALT);
  assign dbg_pc = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multiciclo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_multiciclo : directed bench with a wait-state memory model        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_mips_multiciclo;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] cyc;
  } tx_t;

  logic        clock, reset;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_pc;
  logic        m2_req, m2_we, m2_ready, m2_halted;
  logic [31:0] m2_addr, m2_wdata, m2_rdata, m2_pc;

  logic [31:0] mem  [0:255];
  logic [31:0] mem2 [0:255];
  tx_t         log_q[$];
  tx_t         log2_q[$];
  int          cyc, wait_cnt, rd_wait, hold100, halt_req;
  logic        hold_ready;
  int          total, bad;

  mips_multiciclo #(.RESET_PC(0), .ADDR_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted), .dbg_pc(dbg_pc));

  mips_multiciclo #(.RESET_PC(0), .ADDR_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clock(clock), .reset(reset), .mem_req(m2_req), .mem_we(m2_we),
    .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_rdata(m2_rdata),
    .mem_ready(m2_ready), .halted(m2_halted), .dbg_pc(m2_pc));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reads at or above 0x100 wait rd_wait cycles; hold_ready stalls everything.
  always_comb begin
    mem_rdata = mem[mem_addr[9:2]];
    mem_ready = mem_req && !hold_ready &&
                (wait_cnt >= ((!mem_we && mem_addr >= 32'h100) ? rd_wait : 0));
    m2_rdata  = mem2[m2_addr[9:2]];
    m2_ready  = m2_req;
  end

  always @(posedge clock) begin
    wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
    cyc      <= reset ? 0 : cyc + 1;
    if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      log_q.push_back('{mem_addr, mem_we, mem_wdata, 32'(cyc + 1)});
    end
    if (m2_req && m2_ready) begin
      if (m2_we) mem2[m2_addr[9:2]] <= m2_wdata;
      log2_q.push_back('{m2_addr, m2_we, m2_wdata, 32'(cyc + 1)});
    end
    if (mem_req && !mem_we && mem_addr == 32'h100) hold100 <= hold100 + 1;
    if (halted && mem_req) halt_req <= halt_req + 1;
  end

  function automatic logic [31:0] ei(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                     logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                     logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write data is only compared for write transactions.
  task automatic chk_tx(string tag, input tx_t q[$], int idx, logic [31:0] addr,
                        logic we, logic [31:0] wd, int c);
    logic [127:0] obs, exp;
    if (idx >= q.size()) begin
      check({tag, "_missing"}, 128'(q.size()), 128'(idx + 1));
    end else begin
      obs = {q[idx].addr, we ? q[idx].wdata : 32'd0, 31'd0, q[idx].we, q[idx].cyc};
      exp = {addr, we ? wd : 32'd0, 31'd0, we, 32'(c)};
      check(tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic begin_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic end_reset();
    tick(2);
    #1;
    check("rst_req", 128'(mem_req), 128'(0));
    check("rst_we", 128'(mem_we), 128'(0));
    check("rst_halted", 128'(halted), 128'(0));
    check("rst_pc", 128'(dbg_pc), 128'(0));
    log_q.delete();
    hold100  = 0;
    halt_req = 0;
    reset    = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; rd_wait = 0; hold_ready = 1'b0; hold100 = 0; halt_req = 0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem2[i] = 32'h0;
    mem2[0] = ei(6'h08, 5'd0, 5'd5, 16'd9);
    mem2[1] = 32'hFC05_0001;
    mem2[2] = er(5'd0, 5'd0, 5'd5, 6'h21);
    mem2[3] = ei(6'h2B, 5'd0, 5'd5, 16'h0100);

    // Arithmetic, store, delayed load, halt on illegal opcode
    begin_reset();
    mem[0] = ei(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = ei(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = er(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = ei(6'h2B, 5'd0, 5'd3, 16'h0100);
    mem[4] = ei(6'h23, 5'd0, 5'd4, 16'h0100);
    mem[5] = ei(6'h2B, 5'd0, 5'd4, 16'h0104);
    mem[6] = 32'hFC00_0000;
    rd_wait = 3;
    end_reset();
    tick(55);
    chk_tx("p1_fetch0", log_q, 0, 32'h00, 1'b0, 32'h0, 1);
    chk_tx("p1_fetch_add", log_q, 2, 32'h08, 1'b0, 32'h0, 9);
    chk_tx("p1_sw", log_q, 4, 32'h100, 1'b1, 32'h2, 16);
    chk_tx("p1_lw_fetch", log_q, 5, 32'h10, 1'b0, 32'h0, 17);
    chk_tx("p1_lw_read", log_q, 6, 32'h100, 1'b0, 32'h0, 23);
    chk_tx("p1_after_lw", log_q, 7, 32'h14, 1'b0, 32'h0, 25);
    chk_tx("p1_sw_lwdata", log_q, 8, 32'h104, 1'b1, 32'h2, 28);
    check("p1_hold_cycles", 128'(hold100), 128'(4));
    check("p1_tx_count", 128'(log_q.size()), 128'(10));
    check("p1_halted", 128'(halted), 128'(1));
    check("p1_halt_req", 128'(halt_req), 128'(0));
    chk_tx("nop_fetch4", log2_q, 1, 32'h04, 1'b0, 32'h0, 5);
    chk_tx("nop_fetch8", log2_q, 2, 32'h08, 1'b0, 32'h0, 7);
    chk_tx("nop_fetchC", log2_q, 3, 32'h0C, 1'b0, 32'h0, 9);
    chk_tx("nop_sw", log2_q, 4, 32'h100, 1'b1, 32'h9, 12);
    check("nop_halted", 128'(m2_halted), 128'(0));
    rd_wait = 0;

    // ALU functions: sub/and/or/slt on -3 and 5
    begin_reset();
    mem[0]  = ei(6'h08, 5'd0, 5'd1, 16'hFFFD);
    mem[1]  = ei(6'h08, 5'd0, 5'd2, 16'd5);
    mem[2]  = er(5'd1, 5'd2, 5'd3, 6'h22);
    mem[3]  = er(5'd1, 5'd2, 5'd4, 6'h24);
    mem[4]  = er(5'd1, 5'd2, 5'd5, 6'h25);
    mem[5]  = er(5'd1, 5'd2, 5'd6, 6'h2A);
    mem[6]  = er(5'd2, 5'd1, 5'd7, 6'h2A);
    mem[7]  = ei(6'h2B, 5'd0, 5'd3, 16'h0100);
    mem[8]  = ei(6'h2B, 5'd0, 5'd4, 16'h0104);
    mem[9]  = ei(6'h2B, 5'd0, 5'd5, 16'h0108);
    mem[10] = ei(6'h2B, 5'd0, 5'd6, 16'h010C);
    mem[11] = ei(6'h2B, 5'd0, 5'd7, 16'h0110);
    mem[64] = 32'hDEAD_BEEF;
    mem[65] = 32'hDEAD_BEEF;
    mem[66] = 32'hDEAD_BEEF;
    mem[67] = 32'hDEAD_BEEF;
    mem[68] = 32'hDEAD_BEEF;
    end_reset();
    tick(70);
    check("alu_sub", 128'(mem[64]), 128'(32'hFFFF_FFF8));
    check("alu_and", 128'(mem[65]), 128'(32'h0000_0005));
    check("alu_or", 128'(mem[66]), 128'(32'hFFFF_FFFD));
    check("alu_slt_true", 128'(mem[67]), 128'(32'h1));
    check("alu_slt_false", 128'(mem[68]), 128'(32'h0));

    // beq taken and bne not taken, both at PC 0x08 with $1 == $2
    for (int k = 0; k < 2; k++) begin
      begin_reset();
      mem[0] = ei(6'h08, 5'd0, 5'd1, 16'd7);
      mem[1] = ei(6'h08, 5'd0, 5'd2, 16'd7);
      mem[2] = ei((k == 0) ? 6'h04 : 6'h05, 5'd1, 5'd2, 16'd2);
      end_reset();
      tick(16);
      if (k == 0) chk_tx("beq_taken", log_q, 3, 32'h14, 1'b0, 32'h0, 12);
      else        chk_tx("bne_not_taken", log_q, 3, 32'h0C, 1'b0, 32'h0, 12);
    end

    // Jump, then writes to $0 are discarded
    begin_reset();
    mem[0]  = {6'h02, 26'h40};
    mem[64] = ei(6'h08, 5'd0, 5'd0, 16'd7);
    mem[65] = ei(6'h2B, 5'd0, 5'd0, 16'h0104);
    end_reset();
    tick(16);
    chk_tx("j_target", log_q, 1, 32'h100, 1'b0, 32'h0, 4);
    chk_tx("r0_store", log_q, 3, 32'h104, 1'b1, 32'h0, 11);

    // Halted core restarts at RESET_PC; then reset lands in a stalled fetch
    begin_reset();
    mem[0]  = {6'h02, 26'h40};
    end_reset();
    hold_ready = 1'b1;
    tick(3);
    #1;
    check("stall_req", 128'(mem_req), 128'(1));
    check("stall_addr", 128'(mem_addr), 128'(0));
    check("stall_no_tx", 128'(log_q.size()), 128'(0));
    reset = 1'b1;
    #1;
    check("rst_mid_req", 128'(mem_req), 128'(0));
    tick(1);
    reset      = 1'b0;
    hold_ready = 1'b0;
    log_q.delete();
    #1;
    check("rst_mid_pc", 128'(dbg_pc), 128'(0));
    tick(8);
    chk_tx("resume_fetch", log_q, 0, 32'h00, 1'b0, 32'h0, 1);
    chk_tx("resume_jump", log_q, 1, 32'h100, 1'b0, 32'h0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
